wddl_precharge_seq: RTL

Upstream feeder for WDDL dual-rail registers (e.g. `wddl_dflipflop`). The block accepts single-ended words on a valid/ready handshake and generates the shared precharge/evaluate signal. It drives each word as complementary dual-rail pairs during evaluate and forces all rails low during precharge. It also samples the downstream register's dual-rail outputs to return the captured word and flag rail-encoding violations.

---
 rtl/wddl_precharge_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wddl_precharge_seq.sv
// Purpose: feeds WDDL dual-rail registers. Drives precharge/evaluate, puts complementary rails out, and checks the returned rails.
// Latency: the word is on the rails 1 cycle after the handshake. out_valid_o follows EVAL_CYCLES+1 cycles after the handshake.
// Backpressure: in_ready_o is high only in IDLE. The minimum word period is EVAL_CYCLES+PRE_CYCLES+1 cycles.
module wddl_precharge_seq #(
  parameter int WIDTH       = 4,
  parameter int EVAL_CYCLES = 1,
  parameter int PRE_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             prechrg_o,
  output logic [WIDTH-1:0] d_t_o,
  output logic [WIDTH-1:0] d_f_o,
  input  logic [WIDTH-1:0] q_t_i,
  input  logic [WIDTH-1:0] q_f_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             err_o
);

  localparam int MAX_CYC = (EVAL_CYCLES > PRE_CYCLES) ? EVAL_CYCLES : PRE_CYCLES;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_PRE  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_pre_first;
  logic             r_prechrg;
  logic [WIDTH-1:0] r_d_t;
  logic [WIDTH-1:0] r_d_f;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_err;

  logic w_hs;
  logic w_cnt_zero;
  logic w_eval_viol;
  logic w_pre_viol;

  assign w_hs       = in_valid_i & r_in_ready;
  assign w_cnt_zero = (r_cnt == '0);
  // During evaluate, each bit must differ from its complement. Equal rails on any bit are an encoding fault.
  assign w_eval_viol = |(~(q_t_i ^ q_f_i));
  // After the first discharge cycle, every rail must be low during precharge.
  assign w_pre_viol  = |(q_t_i | q_f_i);

  assign in_ready_o  = r_in_ready;
  assign prechrg_o   = r_prechrg;
  assign d_t_o       = r_d_t;
  assign d_f_o       = r_d_f;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign err_o       = r_err;

  // Phase sequencer. prechrg and the rails update on the same edge, so evaluate never shows all-zero rails.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_pre_first <= 1'b0;
      r_prechrg   <= 1'b1;
      r_d_t       <= '0;
      r_d_f       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_word     <= in_data_i;
            r_cnt      <= EVAL_LOAD;
            r_state    <= S_EVAL;
            r_prechrg  <= 1'b0;
            r_d_t      <= in_data_i;
            r_d_f      <= ~in_data_i;
            r_in_ready <= 1'b0;
          end
        end
        S_EVAL: begin
          // The word register is the single source for the rails while evaluating.
          r_d_t <= r_word;
          r_d_f <= ~r_word;
          if (w_cnt_zero) begin
            r_out_data  <= q_t_i;
            r_out_valid <= 1'b1;
            if (w_eval_viol) r_err <= 1'b1;
            r_cnt       <= PRE_LOAD;
            r_state     <= S_PRE;
            r_pre_first <= 1'b1;
            r_prechrg   <= 1'b1;
            r_d_t       <= '0;
            r_d_f       <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PRE: begin
          r_pre_first <= 1'b0;
          // The first precharge cycle is exempt. It gives the downstream register time to discharge.
          if (!r_pre_first && w_pre_viol) r_err <= 1'b1;
          if (w_cnt_zero) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_prechrg  <= 1'b1;
          r_d_t      <= '0;
          r_d_f      <= '0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
